// File: rtl/uart_rx_fifo_if.sv
// Host-side bus of the UART receive FIFO: receiver write strobe, host pop and status.
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              wr_tick;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              clr_overrun;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   level;
    logic              overrun;

    // Receiver/host side drives strobes and observes the FIFO state
    modport master (
        output wr_tick, wr_data, rd_en, clr_overrun,
        input  rd_data, empty, full, almost_full, level, overrun
    );

    // FIFO side
    modport slave (
        input  wr_tick, wr_data, rd_en, clr_overrun,
        output rd_data, empty, full, almost_full, level, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind a UART receiver, with level,
// almost-full and a sticky overrun flag for bytes dropped while full.
module uart_rx_fifo #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_fifo_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned LVL_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overrun_q, overrun_d;

    logic              empty_c;
    logic              full_c;
    logic              wr_acc_c;
    logic              rd_acc_c;
    logic              drop_c;

    // Flags decoded from the registered level counter
    assign empty_c = (level_q == LVL_W'(0));
    assign full_c  = (level_q == LVL_W'(DEPTH));

    // Accept/drop decisions and next-state for pointers, level and overrun
    always_comb begin
        wr_acc_c  = 1'b0;
        rd_acc_c  = 1'b0;
        drop_c    = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        overrun_d = overrun_q;

        // A pop frees a slot in the same cycle, so full+read still accepts the write
        wr_acc_c = bus.wr_tick & (~full_c | bus.rd_en);
        rd_acc_c = bus.rd_en & ~empty_c;
        drop_c   = bus.wr_tick & full_c & ~bus.rd_en;

        if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc_c) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (wr_acc_c && !rd_acc_c) begin
            level_d = level_q + LVL_W'(1);
        end else if (rd_acc_c && !wr_acc_c) begin
            level_d = level_q - LVL_W'(1);
        end

        // A new drop takes priority over a coincident clear
        if (drop_c) begin
            overrun_d = 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // Pointer, level and overrun registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage array; contents are not reset, validity is tracked by level
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    // Output drive: head entry falls through combinationally
    assign bus.rd_data     = mem_q[rd_ptr_q];
    assign bus.empty       = empty_c;
    assign bus.full        = full_c;
    assign bus.almost_full = (level_q >= LVL_W'(AF_LEVEL));
    assign bus.level       = level_q;
    assign bus.overrun     = overrun_q;
endmodule
